// File: rtl/calc_alu_seq_if.sv
// Request/response bundle between the operand registers and the sequential ALU.
// The master drives the request; the slave (the ALU) returns result, flags and status.
interface calc_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   result;
  logic                 carry;
  logic                 div_zero;
  logic                 busy;
  logic                 done;

  modport master (
    output start, op, a, b,
    input  result, carry, div_zero, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, carry, div_zero, busy, done
  );
endinterface

// File: rtl/calc_alu_seq.sv
// Sequential calculator ALU: single-cycle add/sub, shift-add multiply and
// restoring divide, one operation in flight, start/busy/done handshake.
module calc_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  calc_alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADDSUB, MUL, DIV} state_t;

  state_t               state_q, state_d;
  logic                 sub_q, sub_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 div_zero_q, div_zero_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       diff_w;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH:0]       shifted;
  logic [WIDTH-1:0]     trial;
  logic                 ge;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;
  logic                 last;

  assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w  = {1'b0, a_q} - {1'b0, b_q};
  assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Partial remainder always fits WIDTH bits after the subtract, so the
  // trial difference only needs the low WIDTH bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, b_q});
  assign trial   = shifted[WIDTH-1:0] - b_q;
  assign rem_nxt = ge ? trial : shifted[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ge};
  assign last    = (cnt_q == CW'(1));

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (bus.op)
            2'b10:   state_d = MUL;
            2'b11:   state_d = DIV;
            default: state_d = ADDSUB;
          endcase
          sub_d      = bus.op[0];
          a_d        = bus.a;
          b_d        = bus.b;
          acc_d      = '0;
          mcand_d    = {{WIDTH{1'b0}}, bus.a};
          mplier_d   = bus.b;
          rem_d      = '0;
          quo_d      = bus.a;
          cnt_d      = CW'(WIDTH);
          result_d   = '0;
          carry_d    = 1'b0;
          div_zero_d = 1'b0;
        end
      end

      ADDSUB: begin
        result_d = {{WIDTH{1'b0}}, (sub_q ? diff_w[WIDTH-1:0] : sum_w[WIDTH-1:0])};
        carry_d  = sub_q ? diff_w[WIDTH] : sum_w[WIDTH];
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (last) begin
          result_d = acc_nxt;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      DIV: begin
        if (b_q == '0) begin
          result_d   = {a_q, {WIDTH{1'b1}}};
          div_zero_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q - CW'(1);
          if (last) begin
            result_d = {rem_nxt, quo_nxt};
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sub_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.div_zero = div_zero_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Bench for calc_alu_seq: directed vector table, handshake corner sequences and
// randomized operations against an arithmetic reference model, at WIDTH 8 and 4.
module tb_calc_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        st;
  logic        sel;
  logic [1:0]  opv;
  logic [15:0] av;
  logic [15:0] bv;

  int vectors;
  int miscompares;

  calc_alu_seq_if #(.WIDTH(8)) bus8 ();
  calc_alu_seq_if #(.WIDTH(4)) bus4 ();

  calc_alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  calc_alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  assign bus8.start = st & ~sel;
  assign bus8.op    = opv;
  assign bus8.a     = av[7:0];
  assign bus8.b     = bv[7:0];
  assign bus4.start = st & sel;
  assign bus4.op    = opv;
  assign bus4.a     = av[3:0];
  assign bus4.b     = bv[3:0];

  logic [31:0] res_m;
  logic        carry_m, dz_m, busy_m, done_m;
  assign res_m   = sel ? {24'd0, bus4.result} : {16'd0, bus8.result};
  assign carry_m = sel ? bus4.carry    : bus8.carry;
  assign dz_m    = sel ? bus4.div_zero : bus8.div_zero;
  assign busy_m  = sel ? bus4.busy     : bus8.busy;
  assign done_m  = sel ? bus4.done     : bus8.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [1:0]  op;
    int unsigned a;
    int unsigned b;
    logic [31:0] res;
    bit          c;
    bit          dz;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the arithmetic each operation is defined to produce.
  task automatic model(input int w, input logic [1:0] op, input int unsigned x, input int unsigned y,
                       output logic [31:0] r, output bit c, output bit dz, output int lat);
    int unsigned mask;
    int unsigned s;
    mask = (32'd1 << w) - 32'd1;
    c = 1'b0; dz = 1'b0; lat = w;
    case (op)
      2'd0: begin s = x + y; r = s & mask; c = ((s >> w) != 0); lat = 1; end
      2'd1: begin r = (x - y) & mask; c = (x < y); lat = 1; end
      2'd2: r = x * y;
      default: begin
        if (y == 0) begin r = (x << w) | mask; dz = 1'b1; lat = 1; end
        else r = ((x % y) << w) | (x / y);
      end
    endcase
  endtask

  // Issues one operation, scrambles inputs and pokes start while busy, then
  // checks latency, results, single-cycle done and hold-after-done.
  task automatic run(input string name, input bit s, input logic [1:0] o, input int unsigned x,
                     input int unsigned y, input logic [31:0] er, input bit ec, input bit edz,
                     input int elat);
    int          n;
    bit          seen;
    logic [31:0] held;
    sel = s; opv = o; av = 16'(x); bv = 16'(y); st = 1'b1;
    tick();
    st = 1'b0;
    check({name, ".busy_acc"}, 32'(busy_m), 32'd1);
    check({name, ".clr_acc"}, res_m, 32'd0);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      opv = 2'($urandom); av = 16'($urandom); bv = 16'($urandom);
      st  = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (done_m) seen = 1'b1;
    end
    st = 1'b0;
    check({name, ".lat"}, 32'(n), 32'(elat));
    check({name, ".res"}, res_m, er);
    check({name, ".carry"}, 32'(carry_m), 32'(ec));
    check({name, ".dz"}, 32'(dz_m), 32'(edz));
    check({name, ".busy_done"}, 32'(busy_m), 32'd0);
    held = res_m;
    tick();
    check({name, ".done_pulse"}, 32'(done_m), 32'd0);
    check({name, ".idle_after"}, 32'(busy_m), 32'd0);
    check({name, ".hold"}, res_m, held);
  endtask

  initial begin
    logic [31:0] er;
    bit          ec, edz;
    int          el, w, dn;
    int unsigned x, y;
    logic [1:0]  o;

    vectors = 0; miscompares = 0;
    rst_n = 1'b0; st = 1'b0; sel = 1'b0; opv = 2'd0; av = 16'd0; bv = 16'd0;

    tbl.push_back('{0, 2'd0, 200, 100, 32'h002C, 1, 0, 1});
    tbl.push_back('{0, 2'd1,   5,   7, 32'h00FE, 1, 0, 1});
    tbl.push_back('{0, 2'd1,   7,   5, 32'h0002, 0, 0, 1});
    tbl.push_back('{0, 2'd2, 255, 255, 32'hFE01, 0, 0, 8});
    tbl.push_back('{0, 2'd3, 200,   7, 32'h041C, 0, 0, 8});
    tbl.push_back('{0, 2'd3,  13,   0, 32'h0DFF, 0, 1, 1});
    tbl.push_back('{0, 2'd0, 255,   1, 32'h0000, 1, 0, 1});
    tbl.push_back('{0, 2'd1,   0, 255, 32'h0001, 1, 0, 1});
    tbl.push_back('{0, 2'd2,  16,  16, 32'h0100, 0, 0, 8});
    tbl.push_back('{0, 2'd2,   0, 200, 32'h0000, 0, 0, 8});
    tbl.push_back('{0, 2'd3,   5, 200, 32'h0500, 0, 0, 8});
    tbl.push_back('{0, 2'd3, 255,   1, 32'h00FF, 0, 0, 8});
    tbl.push_back('{0, 2'd3, 255, 255, 32'h0001, 0, 0, 8});
    tbl.push_back('{1, 2'd0,   9,   8, 32'h0001, 1, 0, 1});
    tbl.push_back('{1, 2'd2,  15,  15, 32'h00E1, 0, 0, 4});
    tbl.push_back('{1, 2'd3,  13,   3, 32'h0014, 0, 0, 4});
    tbl.push_back('{1, 2'd3,   7,   0, 32'h007F, 0, 1, 1});
    tbl.push_back('{1, 2'd1,   3,  12, 32'h0007, 1, 0, 1});

    #2;
    check("rst.res",   res_m,            32'd0);
    check("rst.carry", 32'(carry_m),     32'd0);
    check("rst.dz",    32'(dz_m),        32'd0);
    check("rst.busy",  32'(busy_m),      32'd0);
    check("rst.done",  32'(done_m),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    foreach (tbl[i])
      run($sformatf("tbl%0d", i), tbl[i].s, tbl[i].op, tbl[i].a, tbl[i].b,
          tbl[i].res, tbl[i].c, tbl[i].dz, tbl[i].lat);

    // Back-to-back: start held high straight through the first done.
    sel = 1'b0; opv = 2'd1; av = 16'd5; bv = 16'd7; st = 1'b1;
    tick();
    tick();
    check("b2b.done1",  32'(done_m),  32'd1);
    check("b2b.res1",   res_m,        32'h00FE);
    check("b2b.carry1", 32'(carry_m), 32'd1);
    av = 16'd7; bv = 16'd5;
    tick();
    st = 1'b0;
    check("b2b.busy2",  32'(busy_m),  32'd1);
    check("b2b.done2",  32'(done_m),  32'd0);
    check("b2b.clr2",   res_m,        32'd0);
    tick();
    check("b2b.done3",  32'(done_m),  32'd1);
    check("b2b.res2",   res_m,        32'h0002);
    check("b2b.carry2", 32'(carry_m), 32'd0);
    tick();

    // Reset in the middle of a multiply: no done may ever surface.
    sel = 1'b0; opv = 2'd2; av = 16'd9; bv = 16'd9; st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst.res",  res_m,        32'd0);
    check("mrst.busy", 32'(busy_m),  32'd0);
    check("mrst.done", 32'(done_m),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_m) dn++;
    end
    check("mrst.no_done", 32'(dn),     32'd0);
    check("mrst.idle",    32'(busy_m), 32'd0);
    check("mrst.res2",    res_m,       32'd0);
    run("mrst.add", 1'b0, 2'd0, 1, 1, 32'h0002, 1'b0, 1'b0, 1);

    for (int i = 0; i < 80; i++) begin
      sel = (i >= 50);
      w   = sel ? 4 : 8;
      o   = 2'($urandom);
      x   = $urandom_range(0, (1 << w) - 1);
      y   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, (1 << w) - 1);
      model(w, o, x, y, er, ec, edz, el);
      run($sformatf("rnd%0d", i), sel, o, x, y, er, ec, edz, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
